// File: rtl/ring_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of i_ring over a
// 2^(10+2*sel) cycle gate window and holds the (optionally Gray-coded) result for byte readback.
module ring_meter #(
  parameter int pCNT_W = 24,
  parameter bit pGRAY  = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ring,
  input  logic       i_start,
  input  logic [1:0] i_gate_sel,
  input  logic [1:0] i_byte_sel,
  output logic [7:0] o_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ovf
);

  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

  state_t              state_q;
  logic                s0_q, s1_q, s2_q;
  logic                ring_edge;
  logic [1:0]          gsel_q;
  logic [1:0]          arm_q;
  logic [15:0]         win_q;
  logic [15:0]         win_load_d;
  logic [pCNT_W-1:0]   cnt_q;
  logic [pCNT_W-1:0]   result_q;
  logic [pCNT_W-1:0]   result_d;
  logic [23:0]         result_ext;
  logic                ovf_acc_q;
  logic                ovf_q;
  logic                busy_q;
  logic                done_q;

  assign ring_edge = s1_q & ~s2_q;

  always_comb begin
    win_load_d = 16'd1023;
    case (gsel_q)
      2'd0: win_load_d = 16'd1023;
      2'd1: win_load_d = 16'd4095;
      2'd2: win_load_d = 16'd16383;
      2'd3: win_load_d = 16'hFFFF;
      default: win_load_d = 16'd1023;
    endcase
  end

  assign result_d = pGRAY ? (cnt_q ^ (cnt_q >> 1)) : cnt_q;

  // ARM spans three cycles so edges already in flight through the synchronizer are discarded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      gsel_q    <= 2'd0;
      arm_q     <= 2'd0;
      win_q     <= 16'd0;
      cnt_q     <= '0;
      result_q  <= '0;
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      s0_q   <= i_ring;
      s1_q   <= s0_q;
      s2_q   <= s1_q;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q <= ARM;
            gsel_q  <= i_gate_sel;
            arm_q   <= 2'd2;
            busy_q  <= 1'b1;
          end
        end
        ARM: begin
          cnt_q     <= '0;
          ovf_acc_q <= 1'b0;
          win_q     <= win_load_d;
          if (arm_q == 2'd0) state_q <= GATE;
          else               arm_q   <= arm_q - 2'd1;
        end
        GATE: begin
          if (ring_edge) begin
            if (&cnt_q) ovf_acc_q <= 1'b1;
            else        cnt_q     <= cnt_q + {{(pCNT_W-1){1'b0}}, 1'b1};
          end
          if (win_q == 16'd0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            win_q <= win_q - 16'd1;
          end
        end
        DONE: begin
          result_q <= result_d;
          ovf_q    <= ovf_acc_q;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    result_ext = '0;
    result_ext[pCNT_W-1:0] = result_q;
    case (i_byte_sel)
      2'd0:    o_data = result_ext[7:0];
      2'd1:    o_data = result_ext[15:8];
      2'd2:    o_data = result_ext[23:16];
      default: o_data = {7'b0, ovf_q};
    endcase
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_ring_meter.sv
// Directed bench for ring_meter: three instances (binary/24b, Gray/24b, binary/8b) share stimulus
// and are checked against hand-computed edge counts and cycle timing.
module tb_ring_meter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ring = 1'b0;
  logic       start = 1'b0;
  logic [1:0] gate_sel = 2'd0;
  logic [1:0] byte_sel = 2'd0;

  logic [7:0] data_def, data_gray, data_c8;
  logic       busy_def, busy_gray, busy_c8;
  logic       done_def, done_gray, done_c8;
  logic       ovf_def, ovf_gray, ovf_c8;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int ring_period = 0;
  int ring_phase = 0;
  logic [7:0] exp_q[$];

  ring_meter u_def (
    .i_clk(clk), .i_rst_n(rst_n), .i_ring(ring), .i_start(start),
    .i_gate_sel(gate_sel), .i_byte_sel(byte_sel),
    .o_data(data_def), .o_busy(busy_def), .o_done(done_def), .o_ovf(ovf_def)
  );

  ring_meter #(.pGRAY(1'b1)) u_gray (
    .i_clk(clk), .i_rst_n(rst_n), .i_ring(ring), .i_start(start),
    .i_gate_sel(gate_sel), .i_byte_sel(byte_sel),
    .o_data(data_gray), .o_busy(busy_gray), .o_done(done_gray), .o_ovf(ovf_gray)
  );

  ring_meter #(.pCNT_W(8)) u_c8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ring(ring), .i_start(start),
    .i_gate_sel(gate_sel), .i_byte_sel(byte_sel),
    .o_data(data_c8), .o_busy(busy_c8), .o_done(done_c8), .o_ovf(ovf_c8)
  );

  // clock / cycle counter / ring generator (ring moves on the falling edge, away from sampling)
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (ring_period == 0) begin
        ring = 1'b0;
      end else begin
        ring_phase = (ring_phase + 1) % ring_period;
        ring = (ring_phase < ring_period / 2);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // expected byte per instance queued in order def, gray, c8
  task automatic check_bytes(input string tag, input logic [1:0] sel,
                             input logic [7:0] e_def, input logic [7:0] e_gray, input logic [7:0] e_c8);
    byte_sel = sel;
    #1;
    exp_q.push_back(e_def);
    exp_q.push_back(e_gray);
    exp_q.push_back(e_c8);
    check({tag, "/def"},  {24'd0, data_def},  {24'd0, exp_q.pop_front()});
    check({tag, "/gray"}, {24'd0, data_gray}, {24'd0, exp_q.pop_front()});
    check({tag, "/c8"},   {24'd0, data_c8},   {24'd0, exp_q.pop_front()});
  endtask

  task automatic start_pulse(input logic [1:0] gs, output int t0);
    @(negedge clk);
    gate_sel = gs;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int t_done);
    t_done = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done_def) begin
        t_done = cyc;
        break;
      end
    end
    if (t_done < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done_def) seen++;
    end
    check(tag, seen, 32'd0);
  endtask

  // run one measurement; the done cycle (t+4+N) begins at edge t0+N+3
  task automatic measure(input string tag, input logic [1:0] gs, input int n_win);
    int t0, td;
    start_pulse(gs, t0);
    wait_done(tag, n_win + 100, td);
    if (td >= 0) begin
      check({tag, "_lat"}, td - t0, n_win + 3);
      check({tag, "_busy_in_done"}, {29'd0, busy_def, done_gray, done_c8}, 32'h7);
      @(posedge clk);
      #1;
      check({tag, "_after"}, {29'd0, busy_def, done_def, busy_c8}, 32'h0);
    end
  endtask

  initial begin
    int t0, t1, t2, t3;

    // 1: reset
    repeat (3) @(posedge clk);
    #1;
    check_bytes("rst_b0", 2'd0, 8'h00, 8'h00, 8'h00);
    check("rst_flags", {29'd0, busy_def, done_def, ovf_def}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_flags", {29'd0, busy_def, done_def, ovf_def}, 32'h0);
    check_bytes("post_rst_b3", 2'd3, 8'h00, 8'h00, 8'h00);

    // 2: window 1024, period 8 -> 128 (Gray 0xC0)
    ring_period = 8;
    repeat (10) @(posedge clk);
    measure("w1024", 2'd0, 1024);
    check_bytes("w1024_b0", 2'd0, 8'h80, 8'hC0, 8'h80);
    check_bytes("w1024_b1", 2'd1, 8'h00, 8'h00, 8'h00);
    check_bytes("w1024_b3", 2'd3, 8'h00, 8'h00, 8'h00);

    // 3: window 16384, period 4 -> 4096 (Gray 0x1800, 8-bit saturates)
    ring_period = 4;
    repeat (10) @(posedge clk);
    measure("w16k", 2'd2, 16384);
    check_bytes("w16k_b0", 2'd0, 8'h00, 8'h00, 8'hFF);
    check_bytes("w16k_b1", 2'd1, 8'h10, 8'h18, 8'h00);
    check_bytes("w16k_b2", 2'd2, 8'h00, 8'h00, 8'h00);
    check_bytes("w16k_b3", 2'd3, 8'h00, 8'h00, 8'h01);

    // 4: window 4096, period 2 -> 2048 edges; then constant ring -> 0
    ring_period = 2;
    repeat (10) @(posedge clk);
    measure("sat", 2'd1, 4096);
    check_bytes("sat_b0", 2'd0, 8'h00, 8'h00, 8'hFF);
    check_bytes("sat_b1", 2'd1, 8'h08, 8'h0C, 8'h00);
    check_bytes("sat_b3", 2'd3, 8'h00, 8'h00, 8'h01);
    ring_period = 0;
    repeat (10) @(posedge clk);
    measure("zero", 2'd0, 1024);
    check_bytes("zero_b0", 2'd0, 8'h00, 8'h00, 8'h00);
    check_bytes("zero_b1", 2'd1, 8'h00, 8'h00, 8'h00);
    check_bytes("zero_b3", 2'd3, 8'h00, 8'h00, 8'h00);

    // 5a: extra start mid-GATE is ignored
    ring_period = 8;
    repeat (10) @(posedge clk);
    start_pulse(2'd0, t0);
    repeat (500) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", 1200, t1);
    check("ign_lat", t1 - t0, 32'd1027);
    no_done("ign_single", 1100);
    check_bytes("ign_b0", 2'd0, 8'h80, 8'hC0, 8'h80);

    // 5b: asynchronous reset mid-GATE
    start_pulse(2'd0, t0);
    repeat (500) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {29'd0, busy_def, busy_gray, busy_c8}, 32'h0);
    check_bytes("rst_mid_b0", 2'd0, 8'h00, 8'h00, 8'h00);
    check_bytes("rst_mid_b1", 2'd1, 8'h00, 8'h00, 8'h00);
    check_bytes("rst_mid_b2", 2'd2, 8'h00, 8'h00, 8'h00);
    check_bytes("rst_mid_b3", 2'd3, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    no_done("rst_mid_nodone", 1100);

    // 6a: gate_sel change during ARM has no effect
    start_pulse(2'd0, t0);
    gate_sel = 2'd3;
    wait_done("latch", 1200, t1);
    check("latch_lat", t1 - t0, 32'd1027);
    gate_sel = 2'd0;
    repeat (5) @(posedge clk);

    // 6b: start held high -> done every 1029 cycles
    @(negedge clk);
    start = 1'b1;
    wait_done("b2b_1", 1200, t1);
    wait_done("b2b_2", 1200, t2);
    wait_done("b2b_3", 1200, t3);
    start = 1'b0;
    check("b2b_gap1", t2 - t1, 32'd1029);
    check("b2b_gap2", t3 - t2, 32'd1029);
    repeat (5) @(posedge clk);
    check_bytes("b2b_b0", 2'd0, 8'h80, 8'hC0, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
